// File: rtl/sine_pwm_dac.sv
// sine_pwm_dac: 10-bit sine sample to PWM converter with one-entry shadow buffer.
// Optional SINE_PWM_UNDERRUN_CNT_EN adds a saturating 8-bit underrun_count output.
module sine_pwm_dac #(
  parameter int SIGNED_IN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       pwm_out,
  output logic       period_start,
`ifdef SINE_PWM_UNDERRUN_CNT_EN
  output logic [7:0] underrun_count,
`endif
  output logic       underrun
);
  typedef enum logic {EMPTY, FULL} shadow_state_t;
  shadow_state_t state, state_next;
  logic [9:0] cnt, duty_active, shadow, duty_new;
  logic boundary, accept;
  assign duty_new = (SIGNED_IN != 0) ? (sample_in ^ 10'h200) : sample_in;
  assign boundary = cnt == 10'd1023;
  assign sample_ready = rst || state == EMPTY || boundary;
  assign accept = sample_valid && sample_ready;
  // A boundary accept keeps the shadow full; otherwise the boundary drains it.
  always_comb begin
    state_next = state;
    state_next = accept ? FULL : boundary ? EMPTY : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      duty_active <= 10'h200;
      shadow <= '0;
      state <= EMPTY;
      pwm_out <= 1'b0;
      period_start <= 1'b0;
      underrun <= 1'b0;
    end else begin
      cnt <= cnt + 10'd1;
      state <= state_next;
      pwm_out <= cnt < duty_active;
      period_start <= boundary;
      underrun <= boundary && state == EMPTY;
      if (boundary && state == FULL) duty_active <= shadow;
      if (accept) shadow <= duty_new;
    end
  end
`ifdef SINE_PWM_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) underrun_count <= '0;
    else if (boundary && state == EMPTY && underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_sine_pwm_dac.sv
// tb_sine_pwm_dac: randomized and directed bench for sine_pwm_dac against a queue-based reference model.
module tb_sine_pwm_dac;
  logic clk = 1'b0, rst = 1'b1, sample_valid = 1'b0;
  logic [9:0] sample_in = '0;
  logic sample_ready, pwm_out, period_start, underrun;
`ifdef SINE_PWM_UNDERRUN_CNT_EN
  logic [7:0] underrun_count;
`endif
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  sine_pwm_dac #(.SIGNED_IN(1)) dut (
    .clk(clk),
    .rst(rst),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .pwm_out(pwm_out),
    .period_start(period_start),
`ifdef SINE_PWM_UNDERRUN_CNT_EN
    .underrun_count(underrun_count),
`endif
    .underrun(underrun)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    compared++;
    mismatched++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference model: position in period, active duty and a pending-sample queue.
  bit armed = 0;
  int m_cnt = 0, m_duty = 512, m_ucnt = 0;
  bit m_pwm = 0, m_ps = 0, m_ur = 0;
  int m_sh[$];

  task automatic model_step();
    bit bnd, acc;
    if (rst) begin
      armed = 1;
      m_cnt = 0;
      m_duty = 512;
      m_sh.delete();
      m_pwm = 0;
      m_ps = 0;
      m_ur = 0;
      m_ucnt = 0;
    end else if (armed) begin
      bnd = m_cnt == 1023;
      acc = sample_valid && (m_sh.size() == 0 || bnd);
      m_pwm = m_cnt < m_duty;
      m_ps = bnd;
      m_ur = bnd && m_sh.size() == 0;
      if (m_ur && m_ucnt < 255) m_ucnt++;
      if (bnd && m_sh.size() != 0) m_duty = m_sh.pop_front();
      if (acc) m_sh.push_back(int'(sample_in ^ 10'h200));
      m_cnt = (m_cnt + 1) % 1024;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) if (armed) begin
    chk("sample_ready", sample_ready, rst || m_sh.size() == 0 || m_cnt == 1023);
    chk("pwm_out", pwm_out, m_pwm);
    chk("period_start", period_start, m_ps);
    chk("underrun", underrun, m_ur);
`ifdef SINE_PWM_UNDERRUN_CNT_EN
    chk("underrun_count", underrun_count, m_ucnt);
`endif
  end

  // Per-period high-cycle count, closed on each period_start; underrun flag of the same boundary.
  int win = 0;
  int hq[$];
  bit uq[$];
  always @(negedge clk) begin
    if (rst) win = 0;
    else begin
      win += int'(pwm_out);
      if (period_start) begin
        hq.push_back(win);
        uq.push_back(underrun);
        win = 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1;
    sample_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", sample_ready, 1);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_period_start", period_start, 0);
    chk("rst_underrun", underrun, 0);
    @(posedge clk);
    #1;
    rst = 0;
    hq.delete();
    uq.delete();
  endtask

  task automatic wait_cnt(int n);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m_cnt != n && k < 2100);
    if (m_cnt != n) fail("wait_cnt");
    #1;
  endtask

  task automatic send(logic [9:0] v);
    int k = 0;
    sample_in = v;
    sample_valid = 1;
    while (!sample_ready && k < 2100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!sample_ready) fail("send");
    @(posedge clk);
    #1;
    sample_valid = 0;
  endtask

  task automatic wait_periods(int n);
    int k = 0;
    while (hq.size() < n && k < 1100 * n + 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (hq.size() < n) fail("wait_periods");
  endtask

  initial begin
    int n;
    int thr[4] = '{1, 3, 60, 700};
    // No samples: default mid-scale duty, underrun at every boundary.
    do_reset();
    wait_periods(2);
    chk("idle_h0", hq[0], 512);
    chk("idle_h1", hq[1], 512);
    chk("idle_u0", uq[0], 1);
    chk("idle_u1", uq[1], 1);
    // Signed samples 0 and -1, second accepted on the boundary.
    do_reset();
    send(10'h000);
    wait_cnt(500);
    chk("full_ready_low", sample_ready, 0);
    wait_cnt(1023);
    chk("full_ready_bnd", sample_ready, 1);
    send(10'h3FF);
    wait_periods(3);
    chk("signed_h1", hq[1], 512);
    chk("signed_h2", hq[2], 511);
    chk("signed_u0", uq[0], 0);
    chk("signed_u1", uq[1], 0);
    chk("signed_u2", uq[2], 1);
    // Boundary accept with shadow full: duties 100 then 300.
    do_reset();
    send(10'd612);
    send(10'd812);
    wait_periods(3);
    chk("bndfull_h1", hq[1], 100);
    chk("bndfull_h2", hq[2], 300);
    chk("bndfull_u0", uq[0], 0);
    chk("bndfull_u1", uq[1], 0);
    // Boundary accept with shadow empty: duty 700 applied one period late.
    do_reset();
    wait_cnt(1023);
    send(10'd188);
    wait_periods(3);
    chk("bndempty_u0", uq[0], 1);
    chk("bndempty_h1", hq[1], 512);
    chk("bndempty_u1", uq[1], 0);
    chk("bndempty_h2", hq[2], 700);
    // Extreme duties, then reset mid-period.
    do_reset();
    send(10'h200);
    send(10'h1FF);
    wait_periods(3);
    chk("duty0_h1", hq[1], 0);
    chk("duty1023_h2", hq[2], 1023);
    wait_cnt(600);
    chk("pwm_before_rst", pwm_out, 1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    n = 0;
    do begin
      @(negedge clk);
      if (n == 0) chk("pwm_after_rst", pwm_out, 0);
      n++;
    end while (!period_start && n < 2000);
    chk("ps_latency", n - 1, 1024);
    // Randomized traffic at several offered rates with rare resets.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < 1024; i++) begin
        sample_valid = $urandom_range(0, 999) < thr[c % 4];
        sample_in = 10'($urandom);
        rst = $urandom_range(0, 4999) == 0;
        @(posedge clk);
        #1;
      end
    end
    rst = 0;
    sample_valid = 0;
`ifdef SINE_PWM_UNDERRUN_CNT_EN
    do_reset();
    wait_periods(300);
    chk("underrun_count_sat", underrun_count, 255);
`endif
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
